// File: rtl/decoder38_pulse.sv
// decoder38_pulse: buffered 3-to-8 decoder that replays queued codes as
// active-low one-hot pulses of HOLD_CYCLES width, separated by GAP_CYCLES
// of all-ones idle. Codes arrive over a valid/ready handshake into a small
// FIFO. iEI (active-low) gates playback without losing queued codes.
module decoder38_pulse #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          iClk,
  input  logic                          iRst,
  input  logic                          iEI,
  input  logic                          iValid,
  input  logic [2:0]                    iData,
  output logic                          oReady,
  output logic [7:0]                    oData,
  output logic                          oEO,
  output logic [$clog2(FIFO_DEPTH):0]   oCount
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int OCC_W   = PTR_W + 1;
  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int GAP_M1  = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;

  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_M1);
  localparam logic [TMR_W-1:0] TMR_ZERO  = {TMR_W{1'b0}};
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0] OCC_ZERO  = {OCC_W{1'b0}};
  localparam logic [7:0]       LINES_OFF = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // Code c pulls line 7-c low: the exact inverse of the priority encoder map.
  function automatic logic [7:0] decode(input logic [2:0] code);
    decode = ~(8'b1000_0000 >> code);
  endfunction

  logic [2:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;

  state_t           state;
  state_t           state_nxt;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_nxt;
  logic [7:0]       lines;
  logic [7:0]       lines_nxt;
  logic             eo;
  logic             eo_nxt;

  logic             push;
  logic             pop;
  logic             can_start;
  logic [7:0]       head_lines;

  // Ready depends only on the registered occupancy, never on this cycle's pop.
  assign oReady     = ~iRst & (occ != OCC_FULL);
  assign push       = iValid & oReady;
  assign can_start  = (occ != OCC_ZERO);
  assign head_lines = decode(mem[rd_ptr]);

  assign oData  = lines;
  assign oEO    = eo;
  assign oCount = occ;

  // Pulse sequencer: decides the next line pattern and when to pop the FIFO.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    lines_nxt = lines;
    eo_nxt    = eo;
    pop       = 1'b0;
    if (iEI) begin
      // Disabled: abort any pulse; the aborted code is already consumed.
      state_nxt = S_IDLE;
      lines_nxt = LINES_OFF;
      eo_nxt    = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (can_start) begin
            pop       = 1'b1;
            lines_nxt = head_lines;
            eo_nxt    = 1'b1;
            timer_nxt = HOLD_LOAD;
            state_nxt = S_HOLD;
          end else begin
            state_nxt = S_IDLE;
          end
        end
        S_HOLD: begin
          if (timer != TMR_ZERO) begin
            timer_nxt = timer - 1'b1;
          end else if (GAP_CYCLES > 0) begin
            lines_nxt = LINES_OFF;
            eo_nxt    = 1'b0;
            timer_nxt = GAP_LOAD;
            state_nxt = S_GAP;
          end else if (can_start) begin
            // No gap configured: chain the next code with no all-ones cycle.
            pop       = 1'b1;
            lines_nxt = head_lines;
            eo_nxt    = 1'b1;
            timer_nxt = HOLD_LOAD;
            state_nxt = S_HOLD;
          end else begin
            lines_nxt = LINES_OFF;
            eo_nxt    = 1'b0;
            state_nxt = S_IDLE;
          end
        end
        S_GAP: begin
          if (timer != TMR_ZERO) begin
            timer_nxt = timer - 1'b1;
          end else if (can_start) begin
            pop       = 1'b1;
            lines_nxt = head_lines;
            eo_nxt    = 1'b1;
            timer_nxt = HOLD_LOAD;
            state_nxt = S_HOLD;
          end else begin
            state_nxt = S_IDLE;
          end
        end
        default: begin
          lines_nxt = LINES_OFF;
          eo_nxt    = 1'b0;
          timer_nxt = TMR_ZERO;
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= S_IDLE;
      timer <= TMR_ZERO;
      lines <= LINES_OFF;
      eo    <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      lines <= lines_nxt;
      eo    <= eo_nxt;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge iClk) begin
    if (push) begin
      mem[wr_ptr] <= iData;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      occ    <= OCC_ZERO;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder38_pulse.sv
// Bench for decoder38_pulse: directed stimulus pushes expected pulses into
// per-instance queues; negedge monitors pop and compare each pulse as it
// appears. Instance a uses default parameters, instance b has GAP_CYCLES=0.
module tb_decoder38_pulse;

  typedef struct {
    logic [7:0] lines;
    int         len;   // expected pulse width, -1 = unchecked
    int         gap;   // expected all-ones cycles before it, -1 = unchecked
  } exp_t;

  // Hand-computed decode table: code c -> bit 7-c low.
  localparam logic [7:0] LUT [8] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF,
                                     8'hF7, 8'hFB, 8'hFD, 8'hFE};

  logic       clk;
  logic       rst;
  logic       ei_a, valid_a, ready_a, eo_a;
  logic [2:0] data_a, cnt_a;
  logic [7:0] lines_a;
  logic       ei_b, valid_b, ready_b, eo_b;
  logic [2:0] data_b, cnt_b;
  logic [7:0] lines_b;

  int   checks = 0;
  int   errors = 0;
  bit   mon_on = 1'b0;
  exp_t exp_a[$];
  exp_t exp_b[$];

  decoder38_pulse dut_a (
    .iClk(clk), .iRst(rst), .iEI(ei_a), .iValid(valid_a), .iData(data_a),
    .oReady(ready_a), .oData(lines_a), .oEO(eo_a), .oCount(cnt_a)
  );

  decoder38_pulse #(.HOLD_CYCLES(4), .GAP_CYCLES(0), .FIFO_DEPTH(4)) dut_b (
    .iClk(clk), .iRst(rst), .iEI(ei_b), .iValid(valid_b), .iData(data_b),
    .oReady(ready_b), .oData(lines_b), .oEO(eo_b), .oCount(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input int act);
    checks++;
    errors++;
    $display("FAIL %s actual=%0h t=%0t", name, act, $time);
  endtask

  // Push one code into instance `which`; `keep`=0 means it is expected to be discarded.
  task automatic send(input int which, input logic [2:0] code, input int len,
                      input int gap, input bit keep);
    int   waited;
    exp_t e;
    waited  = 0;
    e.lines = LUT[code];
    e.len   = len;
    e.gap   = gap;
    if (which == 0) begin
      valid_a = 1'b1;
      data_a  = code;
      while (!ready_a && waited < 100) begin
        chk("full_count_a", cnt_a, 4);
        @(posedge clk); #1;
        waited++;
      end
      if (keep) exp_a.push_back(e);
    end else begin
      valid_b = 1'b1;
      data_b  = code;
      while (!ready_b && waited < 100) begin
        chk("full_count_b", cnt_b, 4);
        @(posedge clk); #1;
        waited++;
      end
      if (keep) exp_b.push_back(e);
    end
    if (waited >= 100) fail_now("ready_timeout", which);
    @(posedge clk); #1;
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  // Wait until an instance has emitted everything expected and gone idle.
  task automatic drain(input int which);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    while (!done && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (which == 0) done = (exp_a.size() == 0) && !eo_a && (cnt_a == 3'd0);
      else            done = (exp_b.size() == 0) && !eo_b && (cnt_b == 3'd0);
    end
    if (!done) fail_now("drain_timeout", which);
    @(posedge clk); #1;
  endtask

  // Monitor a: consistency every cycle, pulse content/width/gap per pulse.
  logic [7:0] prev_a;
  bit         in_a = 1'b0;
  int         run_a = 0, ff_a = 0;
  exp_t       cur_a;
  always @(negedge clk) begin
    if (mon_on) begin
      chk("eo_vs_lines_a", eo_a, (lines_a != 8'hFF));
      if (eo_a) chk("one_cold_a", $countones(~lines_a), 1);
      if (in_a && (!eo_a || lines_a != prev_a)) begin
        if (cur_a.len >= 0) chk("pulse_len_a", run_a, cur_a.len);
        in_a = 1'b0;
        ff_a = 0;
      end
      if (eo_a && !in_a) begin
        if (exp_a.size() == 0) begin
          fail_now("unexpected_pulse_a", lines_a);
          cur_a.len = -1;
        end else begin
          cur_a = exp_a.pop_front();
          chk("pulse_lines_a", lines_a, cur_a.lines);
          if (cur_a.gap >= 0) chk("gap_len_a", ff_a, cur_a.gap);
        end
        in_a  = 1'b1;
        run_a = 0;
      end
      if (in_a) run_a++; else ff_a++;
      prev_a = lines_a;
    end
  end

  // Monitor b: same checks for the zero-gap instance.
  logic [7:0] prev_b;
  bit         in_b = 1'b0;
  int         run_b = 0, ff_b = 0;
  exp_t       cur_b;
  always @(negedge clk) begin
    if (mon_on) begin
      chk("eo_vs_lines_b", eo_b, (lines_b != 8'hFF));
      if (eo_b) chk("one_cold_b", $countones(~lines_b), 1);
      if (in_b && (!eo_b || lines_b != prev_b)) begin
        if (cur_b.len >= 0) chk("pulse_len_b", run_b, cur_b.len);
        in_b = 1'b0;
        ff_b = 0;
      end
      if (eo_b && !in_b) begin
        if (exp_b.size() == 0) begin
          fail_now("unexpected_pulse_b", lines_b);
          cur_b.len = -1;
        end else begin
          cur_b = exp_b.pop_front();
          chk("pulse_lines_b", lines_b, cur_b.lines);
          if (cur_b.gap >= 0) chk("gap_len_b", ff_b, cur_b.gap);
        end
        in_b  = 1'b1;
        run_b = 0;
      end
      if (in_b) run_b++; else ff_b++;
      prev_b = lines_b;
    end
  end

  // Directed stimulus.
  initial begin
    logic [2:0] bp_codes [6];
    bp_codes = '{3'd5, 3'd2, 3'd7, 3'd0, 3'd3, 3'd6};
    rst = 1'b1;
    ei_a = 1'b0; valid_a = 1'b0; data_a = 3'd0;
    ei_b = 1'b0; valid_b = 1'b0; data_b = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state.
    chk("rst_lines_a", lines_a, 8'hFF);
    chk("rst_eo_a", eo_a, 0);
    chk("rst_count_a", cnt_a, 0);
    chk("rst_ready_a", ready_a, 0);
    chk("rst_lines_b", lines_b, 8'hFF);
    chk("rst_ready_b", ready_b, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready_a", ready_a, 1);
    mon_on = 1'b1;

    // Single code: one-edge latency, 4 cycles low, 1 cycle all-ones, then idle.
    send(0, 3'b010, 4, -1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("single_lines", lines_a, 8'hDF);
      chk("single_eo", eo_a, 1);
    end
    @(posedge clk); #1;
    chk("single_gap_lines", lines_a, 8'hFF);
    chk("single_gap_eo", eo_a, 0);
    @(posedge clk); #1;
    chk("single_idle_count", cnt_a, 0);
    chk("single_idle_eo", eo_a, 0);
    drain(0);

    // Full decode sweep; FIFO fills, so ordering and back-pressure both matter.
    for (int c = 0; c < 8; c++) send(0, 3'(c), 4, (c == 0) ? -1 : 1, 1'b1);
    drain(0);

    // Back-pressure with a second code pattern.
    for (int i = 0; i < 6; i++) send(0, bp_codes[i], 4, (i == 0) ? -1 : 1, 1'b1);
    drain(0);

    // Zero-gap instance: 3'b001 then 3'b110 back to back.
    send(1, 3'b001, 4, -1, 1'b1);
    send(1, 3'b110, 4, 0, 1'b1);
    chk("b2b_first0", lines_b, 8'hBF);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("b2b_first", lines_b, 8'hBF);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("b2b_second", lines_b, 8'hFD);
      chk("b2b_second_eo", eo_b, 1);
    end
    @(posedge clk); #1;
    chk("b2b_end_lines", lines_b, 8'hFF);
    drain(1);

    // Disable during the 2nd hold cycle of 3'b100 with 3'b011 queued.
    send(0, 3'b100, 2, -1, 1'b1);
    send(0, 3'b011, 4, 2, 1'b1);
    @(posedge clk); #1;
    ei_a = 1'b1;
    @(posedge clk); #1;
    chk("dis_lines", lines_a, 8'hFF);
    chk("dis_eo", eo_a, 0);
    chk("dis_count", cnt_a, 1);
    @(posedge clk); #1;
    chk("dis_count_hold", cnt_a, 1);
    chk("dis_lines_hold", lines_a, 8'hFF);
    ei_a = 1'b0;
    @(posedge clk); #1;
    chk("reen_lines", lines_a, 8'hEF);
    chk("reen_eo", eo_a, 1);
    chk("reen_count", cnt_a, 0);
    drain(0);

    // Reset mid-pulse with three codes queued; queued codes must vanish.
    send(0, 3'b001, 3, -1, 1'b1);
    send(0, 3'b100, 0, -1, 1'b0);
    send(0, 3'b111, 0, -1, 1'b0);
    send(0, 3'b010, 0, -1, 1'b0);
    chk("pre_rst_count", cnt_a, 3);
    rst = 1'b1;
    #1;
    chk("in_rst_ready", ready_a, 0);
    @(posedge clk); #1;
    chk("mid_rst_lines", lines_a, 8'hFF);
    chk("mid_rst_eo", eo_a, 0);
    chk("mid_rst_count", cnt_a, 0);
    chk("mid_rst_ready", ready_a, 0);
    rst = 1'b0;
    #1;
    chk("after_rst_ready", ready_a, 1);
    repeat (12) @(posedge clk);
    #1;
    chk("after_rst_count", cnt_a, 0);
    chk("after_rst_eo", eo_a, 0);

    chk("leftover_a", exp_a.size(), 0);
    chk("leftover_b", exp_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder38_pulse.md
Name: decoder38_pulse

Overview:
- Sequential 3-to-8 decoder; the inverse of the team's 8-3 priority encoder.
- Accepts 3-bit codes over a valid/ready handshake and buffers them in a small FIFO.
- Replays each code as an active-low one-hot pulse of programmable width, separated by a programmable idle gap.
- Drives strobe/select lines (LED column, mux select) from encoder output or CPU-written codes.

Parameters:
HOLD_CYCLES, 4, cycles each one-hot pulse stays asserted (>=1)
GAP_CYCLES, 1, cycles oData is all-ones between consecutive pulses (>=0)
FIFO_DEPTH, 4, code buffer entries (power of 2, >=2)

Ports:
iClk  input  1  clock, all logic on rising edge
iRst  input  1  synchronous reset, active-high
iEI  input  1  enable, active-low (0 = enabled), same polarity as encoder iEI
iValid  input  1  iData holds a code to enqueue
iData  input  3  code to decode
oReady  output  1  FIFO can accept; transfer on iValid & oReady at rising edge
oData  output  8  decoded line, active-low one-hot, registered
oEO  output  1  1 while a pulse is asserted on oData, registered
oCount  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Clock iClk, one domain; reset iRst is synchronous and active-high.
- Reset: oData=8'hFF, oEO=0, FIFO empty (oCount=0), FSM=IDLE.
- oReady = ~iRst & (oCount != FIFO_DEPTH). Combinational from registered count only; never depends on pop in the same cycle.
- Decode map (inverse of encoder priority): code c drives oData[7-c]=0, all other bits 1. Examples: 3'b000 -> 8'b01111111; 3'b111 -> 8'b11111110.
- FIFO: push on iValid & oReady; pop when FSM starts a pulse. Simultaneous push and pop keeps oCount unchanged. Order is strict FIFO.
- FSM states IDLE, HOLD, GAP; counter width sized for max(HOLD_CYCLES, GAP_CYCLES).
  - IDLE: if iEI=0 and oCount>0 -> pop, load oData with the decode, oEO=1, cnt=HOLD_CYCLES-1, go HOLD.
  - HOLD: cnt>0 -> decrement. cnt==0 ->
    - GAP_CYCLES>0: oData=FF, oEO=0, cnt=GAP_CYCLES-1, go GAP.
    - GAP_CYCLES==0 and iEI=0 and oCount>0: pop next code directly (back-to-back, no FF cycle), stay HOLD.
    - otherwise: oData=FF, oEO=0, go IDLE.
  - GAP: cnt>0 -> decrement. cnt==0 -> same start rule as IDLE (pop and go HOLD) else go IDLE.
- Latency: code pushed at edge k into an empty FIFO with FSM IDLE -> oData valid after edge k+1. It holds exactly HOLD_CYCLES cycles, then FF for exactly GAP_CYCLES cycles.
- iEI=1 (disable): at the next edge, oData=FF, oEO=0, FSM -> IDLE. Any in-progress pulse is aborted and not replayed. FIFO contents are kept, and pushes continue while not full. Re-enabling starts the next queued code on the following edge.
- FIFO full: oReady=0, and iValid is ignored (no overwrite). An empty FIFO is never popped.
- Reset mid-pulse: the reset edge forces all reset values; queued codes are discarded.
- Pointers wrap modulo FIFO_DEPTH. The count saturates logically via the ready/start guards; no overflow or underflow is possible.

Test Plan:
- Reset then single code: push 3'b010 at edge k -> oData=8'b11011111, oEO=1 for edges k+1..k+4; FF and oEO=0 for 1 cycle; then IDLE with oCount=0.
- Full decode sweep: push codes 0..7 with default params -> oData walks 8'b01111111 ... 8'b11111110, each 4 cycles with a 1-cycle FF gap; order preserved.
- Back-pressure: hold iValid=1 with 6 codes while FSM busy -> oReady drops when oCount=4; no code lost or duplicated; all 6 appear in order.
- GAP_CYCLES=0 build: push 3'b001, 3'b110 -> 8'b10111111 for 4 cycles, immediately followed by 8'b11111101 for 4 cycles, no FF cycle between.
- Disable mid-pulse: iEI=1 during the 2nd HOLD cycle of 3'b100 with 3'b011 queued -> oData=FF next edge, oCount stays 1; iEI=0 -> 3'b011 pulse (8'b11101111) starts one edge later; 3'b100 not replayed.
- Reset mid-operation: iRst=1 for one edge with 3 codes queued and a pulse active -> oData=FF, oEO=0, oCount=0, oReady=0 during reset and 1 after.
